// File: rtl/osc_freq_cal.sv
// Ring-oscillator frequency calibration. It measures osc edges per window and searches the coarse code, then does a SAR on the fine code.
// Latency: about 274 clk per measurement (settle plus window plus capture). A full calibration is a few thousand cycles.
// Backpressure: none. cal_start is ignored while busy. `define OSC_CAL_TRACK_EN adds closed-loop tracking after a successful lock.
module osc_freq_cal #(
  parameter int N_MSB      = 7,
  parameter int N_LSB      = 4,
  parameter int CNT_W      = 12,
  parameter int WIN_CYC    = 256,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic [CNT_W-1:0] osc_cnt_gray,
  output logic [N_MSB-1:0] delay_con_msb,
  output logic [N_LSB-1:0] delay_con_lsb,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_err,
  output logic [CNT_W-1:0] meas_cnt
);

  localparam int TMR_W = $clog2(SETTLE_CYC + WIN_CYC + 2);
  localparam int IDX_W = (N_LSB > 1) ? $clog2(N_LSB) : 1;
  localparam logic [TMR_W-1:0] T_C0  = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] T_C1  = TMR_W'(SETTLE_CYC + WIN_CYC);
  localparam logic [TMR_W-1:0] T_END = TMR_W'(SETTLE_CYC + WIN_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_LSB - 1);

  typedef enum logic [3:0] {
    IDLE, COARSE_MEAS, COARSE_EVAL, FINE_SET, FINE_MEAS, FINE_EVAL, DONE,
    TRACK_MEAS, TRACK_EVAL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sync1, sync2, gray_bin, cnt_bin;
  logic [CNT_W-1:0] c0, c1, target_q;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] fine_idx;
  logic             meas_active, meas_end, start_acc;
  logic             too_fast, msb_full, msb_empty;

  // Two-flop synchroniser for the async Gray count, then a registered decode (3 cycles pin to cnt_bin)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      cnt_bin <= '0;
    end else begin
      sync1   <= osc_cnt_gray;
      sync2   <= sync1;
      cnt_bin <= gray_bin;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    gray_bin = '0;
    for (int i = 0; i < CNT_W; i++) begin
      gray_bin[i] = ^(sync2 >> i);
    end
  end

  assign meas_active = (state == COARSE_MEAS) || (state == FINE_MEAS) || (state == TRACK_MEAS);
  assign meas_end    = meas_active && (timer == T_END);
  assign too_fast    = meas_cnt > target_q;
  assign msb_full    = &delay_con_msb;
  assign msb_empty   = ~|delay_con_msb;
`ifdef OSC_CAL_TRACK_EN
  assign start_acc   = cal_start && ((state == IDLE) || (state == TRACK_MEAS) || (state == TRACK_EVAL));
`else
  assign start_acc   = cal_start && (state == IDLE);
`endif

  // Measurement timer: runs only inside a measuring state and restarts for every window
  always_ff @(posedge clk) begin
    if (rst || !meas_active || meas_end) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Capture start/end counts. Modular subtraction absorbs counter wrap inside the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      c0       <= '0;
      c1       <= '0;
      meas_cnt <= '0;
    end else if (meas_active) begin
      if (timer == T_C0)  c0       <= cnt_bin;
      if (timer == T_C1)  c1       <= cnt_bin;
      if (timer == T_END) meas_cnt <= c1 - c0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (cal_start) state_nxt = COARSE_MEAS;
      COARSE_MEAS: if (meas_end) state_nxt = COARSE_EVAL;
      COARSE_EVAL: begin
        if (too_fast) state_nxt = msb_full ? DONE : COARSE_MEAS;
        else          state_nxt = msb_empty ? DONE : FINE_SET;
      end
      FINE_SET:    state_nxt = FINE_MEAS;
      FINE_MEAS:   if (meas_end) state_nxt = FINE_EVAL;
      FINE_EVAL:   state_nxt = (fine_idx == '0) ? DONE : FINE_SET;
`ifdef OSC_CAL_TRACK_EN
      DONE:        state_nxt = cal_err ? IDLE : TRACK_MEAS;
      TRACK_MEAS: begin
        if (cal_start)     state_nxt = COARSE_MEAS;
        else if (meas_end) state_nxt = TRACK_EVAL;
      end
      TRACK_EVAL:  state_nxt = cal_start ? COARSE_MEAS : TRACK_MEAS;
`else
      DONE:        state_nxt = IDLE;
`endif
      default:     state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from state. Both are low in IDLE, so reset clears them.
  always_comb begin
    cal_busy = (state == COARSE_MEAS) || (state == COARSE_EVAL) || (state == FINE_SET) ||
               (state == FINE_MEAS) || (state == FINE_EVAL);
    cal_done = (state == DONE);
  end

`ifdef OSC_CAL_TRACK_EN
  logic lsb_full, lsb_empty, trk_fast, trk_slow;
  assign lsb_full  = &delay_con_lsb;
  assign lsb_empty = ~|delay_con_lsb;
  // Deadband of +/-1 edge around target. Compare in CNT_W+1 bits so target+1 cannot overflow.
  assign trk_fast  = {1'b0, meas_cnt} > ({1'b0, target_q} + (CNT_W+1)'(1));
  assign trk_slow  = ({1'b0, meas_cnt} + (CNT_W+1)'(1)) < {1'b0, target_q};
`endif

  // Code/target/error datapath. Codes move only in EVAL/SET states, never inside a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q      <= '0;
      delay_con_msb <= '0;
      delay_con_lsb <= '0;
      fine_idx      <= '0;
      cal_err       <= 1'b0;
    end else if (start_acc) begin
      target_q      <= target_cnt;
      delay_con_msb <= '0;
      delay_con_lsb <= '0;
      cal_err       <= 1'b0;
    end else begin
      case (state)
        COARSE_EVAL: begin
          if (too_fast) begin
            if (msb_full) begin
              cal_err       <= 1'b1;
              delay_con_lsb <= '1;
            end else begin
              delay_con_msb <= {delay_con_msb[N_MSB-2:0], 1'b1};
            end
          end else if (msb_empty) begin
            cal_err       <= 1'b1;
            delay_con_lsb <= '0;
          end else begin
            // Step back to the last coarse code that was still too fast; the fine code closes the gap
            delay_con_msb <= delay_con_msb >> 1;
            fine_idx      <= IDX_TOP;
          end
        end
        FINE_SET: delay_con_lsb[fine_idx] <= 1'b1;
        FINE_EVAL: begin
          if (!too_fast) delay_con_lsb[fine_idx] <= 1'b0;
          if (fine_idx != '0) fine_idx <= fine_idx - 1'b1;
        end
`ifdef OSC_CAL_TRACK_EN
        TRACK_EVAL: begin
          if (trk_fast) begin
            if (lsb_full && msb_full) begin
              cal_err <= 1'b1;
            end else if (lsb_full) begin
              delay_con_lsb <= '0;
              delay_con_msb <= {delay_con_msb[N_MSB-2:0], 1'b1};
            end else begin
              delay_con_lsb <= delay_con_lsb + 1'b1;
            end
          end else if (trk_slow) begin
            if (lsb_empty && msb_empty) begin
              cal_err <= 1'b1;
            end else if (lsb_empty) begin
              delay_con_lsb <= '1;
              delay_con_msb <= delay_con_msb >> 1;
            end else begin
              delay_con_lsb <= delay_con_lsb - 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_cal.sv
// Bench for osc_freq_cal. It uses an oscillator model of 2000 - 200*k - 10*lsb edges per 256-cycle window.
// Stimulus pushes expected calibration results into a queue. A monitor pops one result on every cal_done and compares it.
// Runs in the default build (tracking disabled).
module tb_osc_freq_cal;

  logic        clk = 1'b0;
  logic        rst;
  logic        cal_start;
  logic [11:0] target_cnt;
  logic [11:0] osc_cnt_gray;
  logic [6:0]  delay_con_msb;
  logic [3:0]  delay_con_lsb;
  logic        cal_busy, cal_done, cal_err;
  logic [11:0] meas_cnt;

  always #5 clk = ~clk;

  osc_freq_cal dut (
    .clk          (clk),
    .rst          (rst),
    .cal_start    (cal_start),
    .target_cnt   (target_cnt),
    .osc_cnt_gray (osc_cnt_gray),
    .delay_con_msb(delay_con_msb),
    .delay_con_lsb(delay_con_lsb),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .cal_err      (cal_err),
    .meas_cnt     (meas_cnt)
  );

  typedef struct packed {
    logic [6:0]  msb;
    logic [3:0]  lsb;
    logic        err;
    logic [11:0] meas;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Oscillator model. pos_fx is the edge count scaled by 256, advanced once per clk.
  longint pos_fx     = 0;
  longint pos_offset = 0;
  int     rate_ovr   = 0;

  function automatic int osc_rate(input logic [6:0] msb, input logic [3:0] lsb);
    if (rate_ovr != 0) return rate_ovr;
    return 2000 - 200 * $countones(msb) - 10 * int'(lsb);
  endfunction

  initial osc_cnt_gray = '0;
  always @(negedge clk) begin
    logic [11:0] cnt;
    pos_fx = pos_fx + longint'(osc_rate(delay_con_msb, delay_con_lsb));
    cnt = 12'((pos_fx >>> 8) + pos_offset);
    osc_cnt_gray = cnt ^ (cnt >> 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every cal_done cycle must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (cal_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got cal_done=1, expected no completion at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_msb",  32'(delay_con_msb), 32'(e.msb));
          chk("done_lsb",  32'(delay_con_lsb), 32'(e.lsb));
          chk("done_err",  32'(cal_err),       32'(e.err));
          chk("done_meas", 32'(meas_cnt),      32'(e.meas));
          chk("done_busy", 32'(cal_busy),      32'd0);
        end
      end
    end
  end

  task automatic pulse_start(input logic [11:0] tgt);
    @(negedge clk);
    target_cnt = tgt;
    cal_start  = 1'b1;
    @(negedge clk);
    cal_start  = 1'b0;
  endtask

  // Wait for the scoreboard to drain within a cycle budget; an overrun counts as a failure
  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no cal_done in %0d cycles, expected completion", name, budget);
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_msb"},  32'(delay_con_msb), 32'd0);
    chk({name, "_lsb"},  32'(delay_con_lsb), 32'd0);
    chk({name, "_busy"}, 32'(cal_busy),      32'd0);
    chk({name, "_done"}, 32'(cal_done),      32'd0);
    chk({name, "_err"},  32'(cal_err),       32'd0);
    chk({name, "_meas"}, 32'(meas_cnt),      32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    cal_start  = 1'b0;
    target_cnt = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the third coarse window: k=2, then everything clears and no done follows
    pulse_start(12'd1355);
    repeat (650) @(negedge clk);
    chk("midrun_busy", 32'(cal_busy), 32'd1);
    chk("midrun_msb",  32'(delay_con_msb), 32'h03);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrun_rst");
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("post_rst_idle", 32'(cal_busy), 32'd0);

    // Nominal lock: k=3, lsb=0100. The last SAR measurement (bit 0 trial) is 1350. A start while busy is ignored.
    exp_q.push_back('{msb: 7'b0000111, lsb: 4'b0100, err: 1'b0, meas: 12'd1350});
    pulse_start(12'd1355);
    repeat (400) @(negedge clk);
    pulse_start(12'd100);
    wait_done("nominal", 4000);
    chk("hold_msb", 32'(delay_con_msb), 32'h07);
    chk("hold_lsb", 32'(delay_con_lsb), 32'h4);
    chk("hold_err", 32'(cal_err),       32'd0);

    // Unreachable fast: k saturates at 7 and the rate is still 600 > 100
    exp_q.push_back('{msb: 7'h7F, lsb: 4'hF, err: 1'b1, meas: 12'd600});
    pulse_start(12'd100);
    wait_done("fast", 4000);
    chk("err_sticky", 32'(cal_err), 32'd1);

    // Unreachable slow: first eval at k=0 gives 2000 <= 2500
    exp_q.push_back('{msb: 7'h00, lsb: 4'h0, err: 1'b1, meas: 12'd2000});
    pulse_start(12'd2500);
    chk("start_clears_err", 32'(cal_err),  32'd0);
    chk("start_sets_busy",  32'(cal_busy), 32'd1);
    wait_done("slow", 1000);

    // Counter wrap: a fixed 900 edges/window with the count placed near 4000, so 4095->0 falls inside the window.
    // Target equals the rate, so it is "not too fast" at k=0 and ends in error.
    rate_ovr = 900;
    @(posedge clk);
    pos_offset = 64'd4000 - (pos_fx >>> 8);
    exp_q.push_back('{msb: 7'h00, lsb: 4'h0, err: 1'b1, meas: 12'd900});
    pulse_start(12'd900);
    wait_done("wrap", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
